axi4_burst_master: RTL and testbench
====================================

AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master
Interface
REQ-001 SHALL provide port clock  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL provide port reset  in  1  synchronous, active-low reset.
REQ-003 SHALL provide port req_valid  in  1  client request valid.
REQ-004 SHALL provide port req_ready  out  1  block can accept a request.
REQ-005 SHALL provide port req_write  in  1  1 = single-beat write, 0 = read burst.
REQ-006 SHALL provide port req_addr  in  32  byte address of first beat.
REQ-007 SHALL provide port req_len  in  8  read beats minus one; ignored for writes.
REQ-008 SHALL provide port req_wdata  in  32  write data.
REQ-009 SHALL provide port req_wstrb  in  4  write byte strobes.
REQ-010 SHALL provide port rsp_valid  out  1  one-cycle response pulse; client cannot stall it.
REQ-011 SHALL provide port rsp_data  out  32  read beat data; 0 for write responses.
REQ-012 SHALL provide port rsp_last  out  1  final response of the request.
REQ-013 SHALL provide port rsp_err  out  1  non-OKAY response or burst-length mismatch.
REQ-014 SHALL provide port awvalid  out  1  write address valid.
REQ-015 SHALL provide port awready  in  1  write address ready.
REQ-016 SHALL provide port awaddr  out  32  write address.
REQ-017 SHALL provide port wvalid  out  1  write data valid.
REQ-018 SHALL provide port wready  in  1  write data ready.
REQ-019 SHALL provide port wdata  out  32  write data.
REQ-020 SHALL provide port wstrb  out  4  write strobes.
REQ-021 SHALL provide port bvalid  in  1  write response valid.
REQ-022 SHALL provide port bready  out  1  write response ready.
REQ-023 SHALL provide port bresp  in  2  write response code.
REQ-024 SHALL provide port arvalid  out  1  read address valid.
REQ-025 SHALL provide port arready  in  1  read address ready.
REQ-026 SHALL provide port araddr  out  32  read address.
REQ-027 SHALL provide port arlen  out  8  burst beats minus one, incrementing burst.
REQ-028 SHALL provide port rvalid  in  1  read data valid.
REQ-029 SHALL provide port rready  out  1  read data ready.
REQ-030 SHALL provide port rdata  in  32  read data.
REQ-031 SHALL provide port rresp  in  2  read response code.
REQ-032 SHALL provide port rlast  in  1  last read beat.
Function
REQ-033 SHALL implement states IDLE, AR, R, AW_W, B; req_ready = (state==IDLE); accept on req_valid&req_ready, registering addr/len/wdata/wstrb; next state AR (read) or AW_W (write).
REQ-034 AR: arvalid=1, araddr/arlen held stable from the registered request until the arvalid&arready edge, then R; arvalid SHALL never drop without handshake.
REQ-035 R: rready=1; each rvalid edge SHALL produce rsp_valid next cycle with rsp_data=rdata, rsp_err=(rresp!=0)|mismatch, and an 8-bit beat counter incremented.
REQ-036 Counter-based last: rsp_last=1 on beat count==arlen; mismatch = rlast!=(count==arlen); R exits to IDLE on rlast or count==arlen, whichever comes first.
REQ-037 AW_W: awvalid and wvalid both asserted on entry; each SHALL drop the cycle after its own handshake; same-cycle handshakes allowed; transition to B once both have completed.
REQ-038 B: bready=1; on bvalid SHALL pulse rsp_valid next cycle with rsp_last=1, rsp_data=0, rsp_err=(bresp!=0); return to IDLE.
REQ-039 rsp_* SHALL be registered; rsp_valid is high for exactly one cycle per beat/response; no more than one request outstanding.
REQ-040 Responses with any rresp/bresp value SHALL complete the transaction normally (no retry).
REQ-041 No combinational path from any AXI input to any AXI output.
Reset
REQ-042 reset==0 at a rising edge SHALL force IDLE and all outputs to 0 (awvalid, wvalid, arvalid, bready, rready, rsp_*, addresses, arlen), including mid-transaction; req_ready=1 on the first cycle after release.
Verification
REQ-043 Read req_addr=0x30000000 len=0, slave rdata=0x12345678 rlast=1 -> one rsp_valid, rsp_data=0x12345678, rsp_last=1, rsp_err=0.
REQ-044 Read len=3, 4 beats with rvalid gaps of 2 cycles -> 4 rsp pulses, rsp_last only on 4th, arlen=3 held until arready.
REQ-045 Write 0xA0000000 data 0xDEADBEEF strb 0x3, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid after 4, one rsp with rsp_err=0.
REQ-046 Write with bresp=2'b10 -> rsp_valid, rsp_last=1, rsp_err=1; read len=1 with rlast on beat 0 -> rsp_err=1, rsp_last=0, return to IDLE.
REQ-047 reset low during R after 1 of 4 beats -> next cycle all outputs 0, state IDLE; a new read completes correctly.

Source files
------------

// File: rtl/axi4_burst_master.sv
// AXI4 master bridging a simple request/response client to single-beat writes
// and incrementing read bursts, with one request outstanding at a time.
module axi4_burst_master (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] addr_r, wdata_r;
  logic [7:0]  len_r, beat_cnt_r;
  logic [3:0]  wstrb_r;
  logic        aw_done_r, w_done_r;
  logic        rsp_valid_r, rsp_last_r, rsp_err_r;
  logic [31:0] rsp_data_r;

  logic        accept_s, ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic        cnt_last_s, aw_all_s, w_all_s;
  logic        rsp_valid_s, rsp_last_s, rsp_err_s;
  logic [31:0] rsp_data_s;

  // Every AXI output is a flop or a decode of flops, never an AXI input.
  assign req_ready = (state_r == S_IDLE);
  assign arvalid   = (state_r == S_AR);
  assign rready    = (state_r == S_R);
  assign awvalid   = (state_r == S_AW_W) && !aw_done_r;
  assign wvalid    = (state_r == S_AW_W) && !w_done_r;
  assign bready    = (state_r == S_B);
  assign araddr    = addr_r;
  assign awaddr    = addr_r;
  assign arlen     = len_r;
  assign wdata     = wdata_r;
  assign wstrb     = wstrb_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_last  = rsp_last_r;
  assign rsp_err   = rsp_err_r;

  assign accept_s   = req_valid && req_ready;
  assign ar_hs_s    = arvalid && arready;
  assign r_hs_s     = rvalid && rready;
  assign aw_hs_s    = awvalid && awready;
  assign w_hs_s     = wvalid && wready;
  assign b_hs_s     = bvalid && bready;
  assign cnt_last_s = (beat_cnt_r == len_r);
  assign aw_all_s   = aw_done_r || aw_hs_s;
  assign w_all_s    = w_done_r || w_hs_s;

  // Next-state and response decode.
  always_comb begin
    state_s     = state_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = 32'h0000_0000;
    rsp_last_s  = 1'b0;
    rsp_err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (req_write) state_s = S_AW_W;
          else           state_s = S_AR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_AR: begin
        if (ar_hs_s) state_s = S_R;
        else         state_s = S_AR;
      end
      S_R: begin
        if (r_hs_s) begin
          rsp_valid_s = 1'b1;
          rsp_data_s  = rdata;
          rsp_last_s  = cnt_last_s;
          // The counter defines the burst end; a disagreeing rlast is flagged.
          rsp_err_s   = (rresp != 2'b00) || (rlast != cnt_last_s);
          if (rlast || cnt_last_s) state_s = S_IDLE;
          else                     state_s = S_R;
        end else begin
          state_s = S_R;
        end
      end
      S_AW_W: begin
        if (aw_all_s && w_all_s) state_s = S_B;
        else                     state_s = S_AW_W;
      end
      S_B: begin
        if (b_hs_s) begin
          rsp_valid_s = 1'b1;
          rsp_last_s  = 1'b1;
          rsp_err_s   = (bresp != 2'b00);
          state_s     = S_IDLE;
        end else begin
          state_s = S_B;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Registered request fields.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_r  <= 32'h0000_0000;
      len_r   <= 8'd0;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'h0;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      len_r   <= req_len;
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
    end
  end

  // Beat counter and per-channel write handshake tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_cnt_r <= 8'd0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else if (accept_s) begin
      beat_cnt_r <= 8'd0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      if (r_hs_s)  beat_cnt_r <= beat_cnt_r + 8'd1;
      if (aw_hs_s) aw_done_r  <= 1'b1;
      if (w_hs_s)  w_done_r   <= 1'b1;
    end
  end

  // Response registers; rsp_valid is a one-cycle pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0000_0000;
      rsp_last_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_last_r  <= rsp_last_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: negedge-driven AXI slave, table vectors, random
// transactions against a rule-level response model, and reset corner cases.
module tb_axi4_burst_master;

  logic        clock, reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_len;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [1:0]  rresp;

  axi4_burst_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          nbeats;
    logic [1:0]  resp;
    bit          rand_resp;
    int          awd, wd, ard, bd, gap;
    int          exp_n;
    bit          exp_last, exp_err;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [33:0] rsp_q[$];

  // slave configuration and state
  int          aw_delay, w_delay, ar_delay, b_delay, r_gap, r_nbeats;
  logic [31:0] rdata_cfg [0:299];
  logic [1:0]  rresp_cfg [0:299];
  logic [1:0]  bresp_cfg;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_gap_cnt, r_beat, r_wait;
  bit          aw_got, w_got, b_hs, r_hs, r_active;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr, exp_ar_addr;
  logic [3:0]  cap_wstrb;
  logic [7:0]  cap_arlen, exp_ar_len;
  int          aw_cyc, w_cyc, ar_cyc;
  bit          ar_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Response monitor
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) rsp_q.push_back({rsp_data, rsp_last, rsp_err});
  end

  // AXI slave: decides at each falling edge what the next rising edge sees
  always @(negedge clock) begin
    if (!reset) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'h0; rresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_gap_cnt = 0; r_beat = 0; r_wait = 0;
      aw_got = 1'b0; w_got = 1'b0; b_hs = 1'b0; r_hs = 1'b0; r_active = 1'b0;
    end else begin
      if (awvalid) aw_cyc++;
      if (wvalid) w_cyc++;
      if (arvalid) begin
        ar_cyc++;
        if (araddr !== exp_ar_addr || arlen !== exp_ar_len) ar_bad = 1'b1;
      end
      if (b_hs) begin
        bvalid = 1'b0; b_hs = 1'b0;
      end else if (bvalid) begin
        if (bready) b_hs = 1'b1;
      end else if (aw_got && w_got) begin
        if (b_cnt >= b_delay) begin
          bvalid = 1'b1; bresp = bresp_cfg; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
          if (bready) b_hs = 1'b1;
        end else b_cnt++;
      end
      if (awready) awready = 1'b0;
      else if (awvalid) begin
        if (aw_cnt >= aw_delay) begin
          awready = 1'b1; cap_awaddr = awaddr; aw_got = 1'b1; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (wready) wready = 1'b0;
      else if (wvalid) begin
        if (w_cnt >= w_delay) begin
          wready = 1'b1; cap_wdata = wdata; cap_wstrb = wstrb; w_got = 1'b1; w_cnt = 0;
        end else w_cnt++;
      end
      if (r_hs) begin
        rvalid = 1'b0; rlast = 1'b0; r_hs = 1'b0; r_beat++; r_gap_cnt = 0;
        if (r_beat >= r_nbeats) r_active = 1'b0;
      end
      if (rvalid) begin
        if (rready) r_hs = 1'b1;
        else begin
          r_wait++;
          // master has left the burst: abandon the remaining beats
          if (r_wait > 20) begin rvalid = 1'b0; rlast = 1'b0; r_active = 1'b0; end
        end
      end else if (r_active) begin
        if (r_gap_cnt >= r_gap) begin
          rvalid = 1'b1; rdata = rdata_cfg[r_beat]; rresp = rresp_cfg[r_beat];
          rlast = (r_beat == r_nbeats - 1); r_wait = 0;
          if (rready) r_hs = 1'b1;
        end else r_gap_cnt++;
      end
      if (arready) arready = 1'b0;
      else if (arvalid) begin
        if (ar_cnt >= ar_delay) begin
          arready = 1'b1; cap_araddr = araddr; cap_arlen = arlen; ar_cnt = 0;
          r_active = 1'b1; r_beat = 0; r_gap_cnt = 0;
        end else ar_cnt++;
      end
    end
  end

  task automatic setup_slave(input vec_t v);
    aw_delay = v.awd; w_delay = v.wd; ar_delay = v.ard; b_delay = v.bd;
    r_gap = v.gap; r_nbeats = v.nbeats; bresp_cfg = v.resp;
    for (int i = 0; i < 300; i++)
      rresp_cfg[i] = v.rand_resp ? 2'($urandom_range(0, 3)) : v.resp;
    exp_ar_addr = v.addr; exp_ar_len = v.len;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; ar_bad = 1'b0;
    rsp_q.delete();
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [7:0] l,
                       input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    check("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d; req_wstrb = s;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(req_ready === 1'b1 && !r_active && !rvalid && !bvalid && !aw_got && !w_got)
               && n < 2000);
    @(negedge clock);
    check({tag, "_done"}, 64'(n < 2000), 64'd1);
  endtask

  // Expected responses derived from the beat-count and rlast rules
  task automatic run_txn(input vec_t v, input bit hand, input string tag);
    logic [33:0] exp_q[$];
    logic [33:0] tail;
    int m;
    bit lst, err;
    setup_slave(v);
    issue(v.wr, v.addr, v.len, v.wdata, v.wstrb);
    wait_done(tag);
    if (v.wr) begin
      exp_q.push_back({32'h0, 1'b1, v.resp != 2'b00});
      check({tag, "_aw_cycles"}, 64'(aw_cyc), 64'(v.awd + 1));
      check({tag, "_w_cycles"}, 64'(w_cyc), 64'(v.wd + 1));
      check({tag, "_awaddr"}, 64'(cap_awaddr), 64'(v.addr));
      check({tag, "_wdata_wstrb"}, 64'({cap_wdata, cap_wstrb}), 64'({v.wdata, v.wstrb}));
    end else begin
      m = (v.nbeats < int'(v.len) + 1) ? v.nbeats : int'(v.len) + 1;
      for (int i = 0; i < m; i++) begin
        lst = (i == int'(v.len));
        err = (rresp_cfg[i] != 2'b00) || ((i == v.nbeats - 1) != lst);
        exp_q.push_back({rdata_cfg[i], lst, err});
      end
      check({tag, "_ar_cycles"}, 64'(ar_cyc), 64'(v.ard + 1));
      check({tag, "_ar_stable"}, 64'(ar_bad), 64'd0);
      check({tag, "_arlen"}, 64'(cap_arlen), 64'(v.len));
    end
    check({tag, "_rsp_count"}, 64'(rsp_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rsp_q.size(); i++)
      check($sformatf("%s_rsp%0d", tag, i), 64'(rsp_q[i]), 64'(exp_q[i]));
    if (hand) begin
      check({tag, "_hand_count"}, 64'(rsp_q.size()), 64'(v.exp_n));
      if (rsp_q.size() > 0) begin
        tail = rsp_q[rsp_q.size() - 1];
        check({tag, "_hand_last_err"}, 64'(tail[1:0]), 64'({v.exp_last, v.exp_err}));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_last, rsp_err}), 64'd0);
    check({tag, "_addr"}, {awaddr, araddr}, 64'd0);
    check({tag, "_misc"}, 64'({arlen, wstrb, wdata}), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    int n;
    tbl[0]  = '{1'b0, 32'h3000_0000, 8'd0,   32'h0,         4'h0, 1,   2'b00, 1'b0, 0, 0, 0, 0, 0, 1,   1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_1000, 8'd3,   32'h0,         4'h0, 4,   2'b00, 1'b0, 0, 0, 2, 0, 2, 4,   1'b1, 1'b0};
    tbl[2]  = '{1'b1, 32'hA000_0000, 8'd0,   32'hDEAD_BEEF, 4'h3, 1,   2'b00, 1'b0, 3, 0, 0, 0, 0, 1,   1'b1, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0040, 8'd0,   32'hCAFE_F00D, 4'hF, 1,   2'b10, 1'b0, 0, 2, 0, 1, 0, 1,   1'b1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_2000, 8'd1,   32'h0,         4'h0, 1,   2'b00, 1'b0, 0, 0, 0, 0, 0, 1,   1'b0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0000_3000, 8'd2,   32'h0,         4'h0, 5,   2'b00, 1'b0, 0, 0, 1, 0, 1, 3,   1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'h0000_4000, 8'd3,   32'h0,         4'h0, 4,   2'b01, 1'b0, 0, 0, 0, 0, 0, 4,   1'b1, 1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0080, 8'd7,   32'h1122_3344, 4'h1, 1,   2'b00, 1'b0, 0, 0, 0, 2, 0, 1,   1'b1, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_00C0, 8'd0,   32'h5566_7788, 4'h8, 1,   2'b11, 1'b0, 1, 3, 0, 0, 0, 1,   1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0000_5000, 8'd255, 32'h0,         4'h0, 256, 2'b00, 1'b0, 0, 0, 0, 0, 0, 256, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_6000, 8'd3,   32'h0,         4'h0, 2,   2'b00, 1'b0, 0, 0, 1, 0, 0, 2,   1'b0, 1'b1};

    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_len = 8'd0;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_gap = 0; r_nbeats = 1;
    bresp_cfg = 2'b00; exp_ar_addr = 32'h0; exp_ar_len = 8'd0;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs_zero("init_reset");
    reset = 1'b1;
    @(negedge clock);
    check("init_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 300; k++) rdata_cfg[k] = $urandom;
      run_txn(tbl[i], 1'b1, $sformatf("vec%0d", i));
    end

    // single-beat read returning a fixed word
    for (int k = 0; k < 300; k++) rdata_cfg[k] = $urandom;
    rdata_cfg[0] = 32'h1234_5678;
    run_txn(tbl[0], 1'b0, "fixed_read");
    check("fixed_read_value", rsp_q.size() > 0 ? 64'(rsp_q[0]) : 64'h0,
          64'({32'h1234_5678, 1'b1, 1'b0}));

    // reset in the middle of a 4-beat read, after the first beat
    v = tbl[1];
    v.ard = 0; v.gap = 3;
    for (int k = 0; k < 300; k++) rdata_cfg[k] = $urandom;
    setup_slave(v);
    issue(v.wr, v.addr, v.len, v.wdata, v.wstrb);
    n = 0;
    while (rsp_q.size() < 1 && n < 100) begin @(negedge clock); n++; end
    check("midrst_first_beat", 64'(rsp_q.size()), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    check_outputs_zero("midrst");
    check("midrst_rready", 64'(rready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    v = tbl[10];
    v.len = 8'd1;
    v.exp_n = 2; v.exp_last = 1'b1; v.exp_err = 1'b0;
    for (int k = 0; k < 300; k++) rdata_cfg[k] = $urandom;
    run_txn(v, 1'b1, "after_rst");

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      v.len = 8'($urandom_range(0, 15));
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.nbeats = $urandom_range(1, int'(v.len) + 2);
      v.resp = 2'($urandom_range(0, 3));
      v.rand_resp = 1'b1;
      v.awd = $urandom_range(0, 3); v.wd = $urandom_range(0, 3);
      v.ard = $urandom_range(0, 3); v.bd = $urandom_range(0, 2);
      v.gap = $urandom_range(0, 2);
      v.exp_n = 0; v.exp_last = 1'b0; v.exp_err = 1'b0;
      for (int k = 0; k < 300; k++) rdata_cfg[k] = $urandom;
      run_txn(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
